// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage feeding the opcode decoder.
//   - Holds the fetch PC and issues one request at a time to instruction memory
//     (req/addr held stable until the ack cycle, inclusive).
//   - Returned words land in the output register (OUT) or, when OUT is
//     occupied and not draining, in a one-entry skid register (SKID).
//   - A taken-branch redirect flushes OUT/SKID and restarts fetch at the
//     word-aligned target; a request still in flight is drained and dropped.
//
// Ports:
//   clk_i, rst_i                  clock (rising edge), async active-low reset
//   imem_req_o / imem_addr_o      memory request and word-aligned address
//   imem_ack_i / imem_data_i      memory acknowledge and returned word
//   redirect_i / redirect_pc_i    branch taken and its target
//   stall_i                       decoder not accepting this cycle
//   valid_o, instr_o, instr_op_o  instruction to decoder (+ opcode field)
//   pc_o, pc_plus4_o              address of instr_o and that address + PC_STEP
//
// Optional build macro FETCH_PERF_EN adds fetch_cnt_o (transfers) and
// stall_cnt_o (cycles with valid_o=1 and stall_i=1), both wrapping 32-bit.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = {ADDR_W{1'b0}},
    parameter int                PC_STEP  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_data_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              stall_i,
    output logic              valid_o,
    output logic [31:0]       instr_o,
    output logic [5:0]        instr_op_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    // REQ: no request on the bus (waiting for SKID space)
    // WAIT: request outstanding, its word is wanted
    // DROP: request outstanding, its word is wrong-path and will be discarded
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [1:0]        r_state,      w_state_n;
    logic              r_req,        w_req_n;
    logic [ADDR_W-1:0] r_addr,       w_addr_n;
    logic [ADDR_W-1:0] r_pc,         w_pc_n;       // address of next word to request
    logic              r_valid,      w_valid_n;
    logic [31:0]       r_instr,      w_instr_n;
    logic [ADDR_W-1:0] r_out_pc,     w_out_pc_n;
    logic [ADDR_W-1:0] r_out_pc4,    w_out_pc4_n;
    logic              r_skid_vld,   w_skid_vld_n;
    logic [31:0]       r_skid_instr, w_skid_instr_n;
    logic [ADDR_W-1:0] r_skid_pc,    w_skid_pc_n;

    logic              w_xfer;
    logic              w_ack;
    logic              w_out_free;
    logic              w_skid_free;
    logic [ADDR_W-1:0] w_target;

    assign w_xfer      = r_valid & ~stall_i;
    assign w_ack       = r_req & imem_ack_i;
    // OUT can take a new word this edge if empty, or draining with nothing behind it
    assign w_out_free  = ~r_valid | (w_xfer & ~r_skid_vld);
    // SKID is empty after this edge if empty now or moving into OUT
    assign w_skid_free = ~r_skid_vld | w_xfer;
    assign w_target    = {redirect_pc_i[ADDR_W-1:2], 2'b00};

    // Next-state computation for fetch FSM, OUT and SKID
    always_comb begin
        w_state_n      = r_state;
        w_req_n        = r_req;
        w_addr_n       = r_addr;
        w_pc_n         = r_pc;
        w_valid_n      = r_valid;
        w_instr_n      = r_instr;
        w_out_pc_n     = r_out_pc;
        w_out_pc4_n    = r_out_pc4;
        w_skid_vld_n   = r_skid_vld;
        w_skid_instr_n = r_skid_instr;
        w_skid_pc_n    = r_skid_pc;

        // Drain: a transfer either refills OUT from SKID or empties OUT
        if (w_xfer && r_skid_vld) begin
            w_valid_n    = 1'b1;
            w_instr_n    = r_skid_instr;
            w_out_pc_n   = r_skid_pc;
            w_out_pc4_n  = r_skid_pc + STEP;
            w_skid_vld_n = 1'b0;
        end else if (w_xfer) begin
            w_valid_n = 1'b0;
        end else begin
            w_valid_n = r_valid;
        end

        if (redirect_i) begin
            w_pc_n       = w_target;
            w_valid_n    = 1'b0;
            w_skid_vld_n = 1'b0;
            if (r_req && !w_ack) begin
                // Keep req/addr held; the late word is thrown away in DROP
                w_state_n = ST_DROP;
            end else begin
                // Bus is free this edge: go straight to the target
                w_req_n   = 1'b1;
                w_addr_n  = w_target;
                w_state_n = ST_WAIT;
            end
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_skid_free) begin
                        w_req_n   = 1'b1;
                        w_addr_n  = r_pc;
                        w_state_n = ST_WAIT;
                    end else begin
                        w_req_n = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (w_ack) begin
                        w_pc_n = r_pc + STEP;
                        if (w_out_free) begin
                            w_valid_n   = 1'b1;
                            w_instr_n   = imem_data_i;
                            w_out_pc_n  = r_pc;
                            w_out_pc4_n = r_pc + STEP;
                            // SKID stays empty, so the next fetch can go out at once
                            w_req_n     = 1'b1;
                            w_addr_n    = r_pc + STEP;
                        end else begin
                            w_skid_vld_n   = 1'b1;
                            w_skid_instr_n = imem_data_i;
                            w_skid_pc_n    = r_pc;
                            w_req_n        = 1'b0;
                            w_state_n      = ST_REQ;
                        end
                    end else begin
                        w_req_n = r_req;
                    end
                end
                ST_DROP: begin
                    if (w_ack) begin
                        // Buffers were flushed by the redirect, so issue at the target now
                        w_req_n   = 1'b1;
                        w_addr_n  = r_pc;
                        w_state_n = ST_WAIT;
                    end else begin
                        w_req_n = r_req;
                    end
                end
                default: begin
                    w_req_n   = 1'b0;
                    w_state_n = ST_REQ;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ST_REQ;
            r_req        <= 1'b0;
            r_addr       <= {ADDR_W{1'b0}};
            r_pc         <= PC_RESET;
            r_valid      <= 1'b0;
            r_instr      <= 32'd0;
            r_out_pc     <= {ADDR_W{1'b0}};
            r_out_pc4    <= {ADDR_W{1'b0}};
            r_skid_vld   <= 1'b0;
            r_skid_instr <= 32'd0;
            r_skid_pc    <= {ADDR_W{1'b0}};
        end else begin
            r_state      <= w_state_n;
            r_req        <= w_req_n;
            r_addr       <= w_addr_n;
            r_pc         <= w_pc_n;
            r_valid      <= w_valid_n;
            r_instr      <= w_instr_n;
            r_out_pc     <= w_out_pc_n;
            r_out_pc4    <= w_out_pc4_n;
            r_skid_vld   <= w_skid_vld_n;
            r_skid_instr <= w_skid_instr_n;
            r_skid_pc    <= w_skid_pc_n;
        end
    end

    assign imem_req_o  = r_req;
    assign imem_addr_o = r_addr;
    assign valid_o     = r_valid;
    assign instr_o     = r_instr;
    assign instr_op_o  = r_instr[31:26];
    assign pc_o        = r_out_pc;
    assign pc_plus4_o  = r_out_pc4;

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    // Transfer and stall-cycle counters, wrapping at 2^32
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_xfer) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (r_valid && stall_i) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the opcode decoder.
- Holds the PC and runs a single-outstanding req/ack handshake to instruction memory.
- Buffers returned words and presents instr_o / instr_op_o to the decoder with a valid/stall handshake.
- Accepts taken-branch redirects from the branch-resolution logic and discards wrong-path fetches.

Parameters:
- ADDR_W, 32, PC and memory address width.
- PC_RESET, 0, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- imem_req_o  out  1  fetch request to instruction memory.
- imem_addr_o  out  ADDR_W  fetch address, word aligned.
- imem_ack_i  in  1  memory returns imem_data_i this cycle.
- imem_data_i  in  32  fetched instruction word.
- redirect_i  in  1  branch taken; refetch from redirect_pc_i.
- redirect_pc_i  in  ADDR_W  branch target.
- stall_i  in  1  downstream not accepting this cycle.
- valid_o  out  1  instr_o / pc_o hold a valid instruction.
- instr_o  out  32  instruction word.
- instr_op_o  out  6  instr_o[31:26], feeds the decoder opcode input.
- pc_o  out  ADDR_W  address of instr_o.
- pc_plus4_o  out  ADDR_W  pc_o + PC_STEP, for the branch adder.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - fetch PC = PC_RESET; state = REQ.
  - valid_o=0, instr_o=0, pc_o=0, pc_plus4_o=0.
  - imem_req_o=0, imem_addr_o=0; skid buffer empty.
  - imem_req_o may first assert in the cycle after rst_i deasserts.
- Storage:
  - Output register (OUT) drives valid_o, instr_o, pc_o.
  - One-entry skid register (SKID) holds a word plus its PC.
- Transfer: occurs when valid_o=1 and stall_i=0.
- Memory handshake:
  - imem_req_o and imem_addr_o stay stable from assertion until the cycle imem_ack_i=1 (inclusive).
  - At most one outstanding request.
  - imem_ack_i while imem_req_o=0 is ignored.
- FSM states: REQ, WAIT, DROP.
- REQ:
  - Assert imem_req_o with imem_addr_o = fetch PC, only when SKID is empty.
  - Ack in the same cycle is legal (zero wait) and handled as in WAIT.
  - Otherwise go to WAIT.
- WAIT (on ack):
  - If OUT is empty, or a transfer happens this cycle: load OUT with data and fetch PC.
  - Else: load SKID.
  - Fetch PC += PC_STEP, wrapping modulo 2^ADDR_W; return to REQ.
- OUT refill: on transfer, if SKID is full, OUT loads from SKID the next edge and SKID empties.
- Latency: zero-wait memory and no stall gives valid_o 1 cycle after ack; steady throughput is 1 instruction per cycle.
- Redirect (highest priority, same edge):
  - Fetch PC = {redirect_pc_i[ADDR_W-1:2], 2'b00}.
  - OUT and SKID are invalidated; valid_o=0 next cycle even when stall_i=1.
  - Request outstanding and not acked this cycle: go to DROP. Req/addr stay held until ack, the returned word is discarded, then go to REQ at the new PC.
  - Redirect in the same cycle as ack: the word is discarded; the next request is at the new PC.
  - Redirect during DROP: only the target PC is updated; the drop continues.
- instr_op_o is combinational from instr_o; pc_plus4_o is registered together with pc_o.
- No instruction is ever duplicated or lost across stall/ack combinations.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output ports fetch_cnt_o[31:0] (count of transfers) and stall_cnt_o[31:0] (cycles with valid_o=1 and stall_i=1).
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, zero-wait memory returning addr+0x100, stall_i=0 -> pc_o sequence 0,4,8,12 on consecutive cycles; instr_o = 0x100, 0x104, ...; instr_op_o = instr_o[31:26].
- Memory ack delayed 3 cycles -> imem_addr_o held stable for 4 cycles; valid_o pulses once per fetch; no repeated pc_o.
- stall_i=1 for 5 cycles with valid_o=1 -> OUT and SKID fill, imem_req_o drops; on release, pc_o 8 then 12 appear back-to-back with nothing lost.
- redirect_i=1, redirect_pc_i=0x43 while WAIT at 0x10 -> ack for 0x10 discarded; next request at 0x40; first valid pc_o=0x40; valid_o=0 during the redirect gap.
- redirect_i coincident with ack and stall_i=1 -> valid_o=0 next cycle; next imem_addr_o = target.
- rst_i asserted mid-WAIT -> all outputs 0 immediately; after release the first imem_addr_o = PC_RESET; with FETCH_PERF_EN defined, counters read 0.
